// File: rtl/ibias_seq.sv
// Sequencer for the brownout bias generator: start-up source, bandgap wait, source switch, ready/fault.
// Latency: outputs registered from next state (1 edge); bg_rdy reaches the FSM after a 2-flop synchronizer.
// Backpressure: none; en_req=0 forces OFF on the next edge from any state.
module ibias_seq #(
    parameter int SETTLE_CYC = 64,
    parameter int BG_TIMEOUT = 1024,
    parameter int CNT_W      = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_req,
    input  logic       bg_rdy,
    output logic       ibias_ena,
    output logic       isrc_sel,
    output logic       bias_rdy,
    output logic       bg_fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_START   = 3'd1,
        ST_BG_WAIT = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_READY   = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BG_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bg_meta_q, bg_meta_d;
    logic               bg_rdy_s_q, bg_rdy_s_d;
    logic               ibias_ena_q, ibias_ena_d;
    logic               isrc_sel_q, isrc_sel_d;
    logic               bias_rdy_q, bias_rdy_d;
    logic               bg_fault_q, bg_fault_d;

    // bg_rdy is asynchronous to clk; only the second flop output is ever used.
    always_comb begin
        bg_meta_d  = bg_rdy;
        bg_rdy_s_d = bg_meta_q;
    end

    always_comb begin
        state_d = state_q;
        if (!en_req) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_START;
                end
                ST_START: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_BG_WAIT;
                    end
                end
                ST_BG_WAIT: begin
                    if (bg_rdy_s_q) begin
                        state_d = ST_SWITCH;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_SWITCH: begin
                    // Losing the bandgap mid-switch outranks finishing the settle.
                    if (!bg_rdy_s_q) begin
                        state_d = ST_BG_WAIT;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (!bg_rdy_s_q) begin
                        state_d = ST_BG_WAIT;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_START || state_q == ST_BG_WAIT || state_q == ST_SWITCH) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs decode the next state so they change on the same edge as state.
    always_comb begin
        ibias_ena_d = 1'b0;
        isrc_sel_d  = 1'b0;
        bias_rdy_d  = 1'b0;
        bg_fault_d  = 1'b0;
        case (state_d)
            ST_START, ST_BG_WAIT: begin
                ibias_ena_d = 1'b1;
            end
            ST_SWITCH: begin
                ibias_ena_d = 1'b1;
                isrc_sel_d  = 1'b1;
            end
            ST_READY: begin
                ibias_ena_d = 1'b1;
                isrc_sel_d  = 1'b1;
                bias_rdy_d  = 1'b1;
            end
            ST_FAULT: begin
                // Start-up source stays on to keep the brownout comparator biased.
                ibias_ena_d = 1'b1;
                bg_fault_d  = 1'b1;
            end
            default: begin
                ibias_ena_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            bg_meta_q   <= 1'b0;
            bg_rdy_s_q  <= 1'b0;
            ibias_ena_q <= 1'b0;
            isrc_sel_q  <= 1'b0;
            bias_rdy_q  <= 1'b0;
            bg_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bg_meta_q   <= bg_meta_d;
            bg_rdy_s_q  <= bg_rdy_s_d;
            ibias_ena_q <= ibias_ena_d;
            isrc_sel_q  <= isrc_sel_d;
            bias_rdy_q  <= bias_rdy_d;
            bg_fault_q  <= bg_fault_d;
        end
    end

    assign ibias_ena = ibias_ena_q;
    assign isrc_sel  = isrc_sel_q;
    assign bias_rdy  = bias_rdy_q;
    assign bg_fault  = bg_fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ibias_seq.sv
// Bench for ibias_seq: directed scenarios plus random en_req/bg_rdy traffic,
// every cycle compared with a mode/dwell reference model.
module tb_ibias_seq;

    localparam int S = 4;
    localparam int T = 8;

    localparam int M_OFF = 0, M_START = 1, M_BGW = 2, M_SW = 3, M_RDY = 4, M_FLT = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_req;
    logic       bg_rdy;
    logic       ibias_ena;
    logic       isrc_sel;
    logic       bias_rdy;
    logic       bg_fault;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    // Reference model: current mode, cycles already spent in it, synchronizer pipeline.
    int   m_mode  = M_OFF;
    int   m_dwell = 0;
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;
    logic prev_ena  = 1'b0;
    logic prev_isrc = 1'b0;

    ibias_seq #(.SETTLE_CYC(S), .BG_TIMEOUT(T), .CNT_W(11)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_req    (en_req),
        .bg_rdy    (bg_rdy),
        .ibias_ena (ibias_ena),
        .isrc_sel  (isrc_sel),
        .bias_rdy  (bias_rdy),
        .bg_fault  (bg_fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_OFF; m_dwell = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        prev_ena = 1'b0; prev_isrc = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic bg);
        int nxt;
        nxt = m_mode;
        if (!en) nxt = M_OFF;
        else if (m_mode == M_OFF) nxt = M_START;
        else if (m_mode == M_START) begin
            if (m_dwell + 1 >= S) nxt = M_BGW;
        end else if (m_mode == M_BGW) begin
            if (m_s2) nxt = M_SW;
            else if (m_dwell + 1 >= T) nxt = M_FLT;
        end else if (m_mode == M_SW) begin
            if (!m_s2) nxt = M_BGW;
            else if (m_dwell + 1 >= S) nxt = M_RDY;
        end else if (m_mode == M_RDY) begin
            if (!m_s2) nxt = M_BGW;
        end
        m_dwell = (nxt == m_mode) ? m_dwell + 1 : 0;
        m_mode  = nxt;
        m_s2 = m_s1;
        m_s1 = bg;
    endtask

    task automatic compare_all(input string tag);
        int e_ena, e_isrc, e_rdy, e_flt;
        e_ena  = (m_mode != M_OFF) ? 1 : 0;
        e_isrc = (m_mode == M_SW || m_mode == M_RDY) ? 1 : 0;
        e_rdy  = (m_mode == M_RDY) ? 1 : 0;
        e_flt  = (m_mode == M_FLT) ? 1 : 0;
        chk({tag, ".state"}, int'(state), m_mode);
        chk({tag, ".ibias_ena"}, int'(ibias_ena), e_ena);
        chk({tag, ".isrc_sel"}, int'(isrc_sel), e_isrc);
        chk({tag, ".bias_rdy"}, int'(bias_rdy), e_rdy);
        chk({tag, ".bg_fault"}, int'(bg_fault), e_flt);
        chk({tag, ".rdy_implies_on"}, int'(bias_rdy & ~(isrc_sel & ibias_ena)), 0);
        if (!prev_ena && ibias_ena) chk({tag, ".isrc_on_ena_rise"}, int'(isrc_sel), int'(prev_isrc));
        prev_ena  = ibias_ena;
        prev_isrc = isrc_sel;
    endtask

    task automatic step(input logic en, input logic bg, input string tag);
        en_req = en;
        bg_rdy = bg;
        @(posedge clk);
        model_edge(en, bg);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int first_a, first_b, saw;
        logic en_r, bg_r;

        rst_n = 1'b0; en_req = 1'b0; bg_rdy = 1'b0;
        #1;
        compare_all("reset_t1");
        @(posedge clk); #1;
        compare_all("reset_edge");
        rst_n = 1'b1;

        // Nominal start-up with bandgap already ready.
        repeat (3) step(1'b0, 1'b1, "nom_pre");
        first_a = -1; first_b = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, "nom");
            if (k == 0) chk("nom_ena_edge0", int'(ibias_ena), 1);
            if (first_a < 0 && isrc_sel) first_a = k;
            if (first_b < 0 && bias_rdy) first_b = k;
        end
        chk("nom_isrc_edge", first_a, 5);
        chk("nom_rdy_edge", first_b, 2 * S + 1);

        // Bandgap loss in READY, then recovery.
        first_a = -1;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, "loss");
            if (first_a < 0 && !bias_rdy) first_a = k;
        end
        chk("loss_latency", first_a, 3);
        chk("loss_state", int'(state), M_BGW);
        first_b = -1;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b1, "recover");
            if (first_b < 0 && bias_rdy) first_b = k;
        end
        chk("recover_latency", first_b, 3 + S);

        // Asynchronous reset in READY must clear outputs without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk); #1;
        compare_all("rst_held");
        rst_n = 1'b1;

        // Bandgap glitch during SWITCH.
        repeat (3) step(1'b0, 1'b1, "gl_pre");
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, "gl_up");
            if (state == 3'(M_SW)) break;
        end
        chk("gl_in_switch", int'(state), M_SW);
        saw = 0; first_a = -1;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, "gl_drop");
            if (bias_rdy) saw = 1;
            if (first_a < 0 && state == 3'(M_BGW)) first_a = k;
        end
        chk("gl_no_rdy_pulse", saw, 0);
        chk("gl_back_edge", first_a, 3);
        repeat (10) step(1'b1, 1'b1, "gl_restore");

        // Bandgap timeout.
        repeat (3) step(1'b0, 1'b0, "to_pre");
        first_a = -1;
        for (int k = 0; k <= 12; k++) begin
            step(1'b1, 1'b0, "timeout");
            if (first_a < 0 && bg_fault) first_a = k;
        end
        chk("to_fault_edge", first_a, S + T);
        step(1'b0, 1'b0, "to_off");
        chk("to_off_ena", int'(ibias_ena), 0);

        // bg_rdy_s rises on the very cycle the timeout would fire.
        repeat (3) step(1'b0, 1'b0, "sim_pre");
        for (int k = 0; k <= S + T; k++) step(1'b1, (k >= S + T - 2), "simul");
        chk("simul_state", int'(state), M_SW);
        chk("simul_fault", int'(bg_fault), 0);

        // Abort in START.
        repeat (2) step(1'b0, 1'b0, "ab_pre");
        step(1'b1, 1'b0, "ab_start");
        step(1'b1, 1'b0, "ab_cnt1");
        step(1'b0, 1'b0, "ab_off");
        chk("abort_state", int'(state), M_OFF);

        // Random traffic.
        bg_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            en_r = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 99) < 8) bg_r = ~bg_r;
            step(en_r, bg_r, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
